// File: rtl/serdes_pkg.sv
// Shared constants for the isolator control-bus serializer/deserializer.
package serdes_pkg;

  // Frame length used when the instantiator does not override it.
  localparam int WIDTH_DEFAULT = 8;

  // Bits of each control frame that carry information (dir/chan, hwflag, cs_n, hwcon).
  // The unused upper bits of a frame are left for the instantiator to ignore.
  localparam int ISO_CTRL_BITS = 4;

endpackage

// File: rtl/strobe_edge_detect.sv
// Rising-edge detector for the parallel strobe (srclk), sampled on the serial clock.
// The history register resets high, so a strobe line that is already high when
// reset is released does not produce a spurious edge.
module strobe_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig_q;

  // Remember the strobe level from the previous serial clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sig_q <= 1'b1;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_sig_q <= i_sig;
    end
  end

  // Combinational pulse: high during the cycle in which the strobe has just risen.
  assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/serializer_deserializer.sv
// Bidirectional shift-register link between FPGA-side parallel registers and the
// single-wire isolator channels. Behaves like a discrete '165 (TX) and '595 (RX),
// with the register strobe sampled on the serial clock.
module serializer_deserializer
  import serdes_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEFAULT,
  parameter bit LAUNCH_NEGEDGE = 1'b0
) (
  input  logic             clk_ser,
  input  logic             reset_n,
  input  logic             clk_par,
  input  logic [WIDTH-1:0] par_in,
  output logic             ser_out,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out,
  output logic             strobe
);

  logic             w_strobe_c;
  logic [WIDTH-1:0] r_tx_sr;
  logic [WIDTH-1:0] r_rx_sr;
  logic [WIDTH-1:0] r_par_out;
  logic             r_strobe;
  logic [WIDTH-1:0] w_rx_next;

  strobe_edge_detect u_strobe_edge_detect (
    .i_clk   (clk_ser),
    .i_rst_n (reset_n),
    .i_sig   (clk_par),
    .o_rise  (w_strobe_c)
  );

  // The received word includes the bit sampled on the same edge as the strobe.
  assign w_rx_next = {r_rx_sr[WIDTH-2:0], ser_in};

  // TX shifter: a strobe loads the parallel word (load beats shift), otherwise shift MSB-first with zero fill.
  always_ff @(posedge clk_ser or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_sr <= '0;
    end else if (w_strobe_c) begin
      r_tx_sr <= par_in;
    end else begin
      r_tx_sr <= {r_tx_sr[WIDTH-2:0], 1'b0};
    end
  end

  // RX shifter runs every cycle; the output word is latched on a strobe and held otherwise.
  always_ff @(posedge clk_ser or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_sr   <= '0;
      r_par_out <= '0;
    end else begin
      r_rx_sr <= w_rx_next;
      if (w_strobe_c) begin
        r_par_out <= w_rx_next;
      end
    end
  end

  // Status-only strobe indication, one cycle after the detected edge.
  always_ff @(posedge clk_ser or negedge reset_n) begin
    if (!reset_n) begin
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_strobe_c;
    end
  end

  generate
    if (LAUNCH_NEGEDGE) begin : g_launch_neg
      logic r_ser_neg;

      // Relaunch the TX bit half a period later for extra hold margin at the isolator.
      always_ff @(negedge clk_ser or negedge reset_n) begin
        if (!reset_n) begin
          r_ser_neg <= 1'b0;
        end else begin
          r_ser_neg <= r_tx_sr[WIDTH-1];
        end
      end

      assign ser_out = r_ser_neg;
    end else begin : g_launch_pos
      assign ser_out = r_tx_sr[WIDTH-1];
    end
  endgenerate

  assign par_out = r_par_out;
  assign strobe  = r_strobe;

endmodule

// File: tb/tb_serializer_deserializer.sv
// Self-checking bench for serializer_deserializer. Two instances share all inputs:
// dut0 launches on the rising edge, dut1 relaunches on the falling edge. A frame-level
// reference model (bit history queue, loaded word plus bit index) predicts all outputs.
module tb_serializer_deserializer;

  localparam int W = 8;

  logic         clk_ser    = 1'b0;
  logic         reset_n    = 1'b0;
  logic         clk_par    = 1'b1;
  logic         ser_in_drv = 1'b0;
  logic         loop_en    = 1'b0;
  logic [W-1:0] par_in     = '0;

  logic         ser_out0, ser_out1, strobe0, strobe1, w_ser_in;
  logic [W-1:0] par_out0, par_out1;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic         m_prev;
  logic [W-1:0] m_word;
  int           m_idx;
  logic         m_hist[$];
  logic [W-1:0] m_par;
  logic         m_strobe;
  logic         m_ser;

  always #5 clk_ser = ~clk_ser;

  assign w_ser_in = loop_en ? ser_out0 : ser_in_drv;

  serializer_deserializer #(.WIDTH(W), .LAUNCH_NEGEDGE(1'b0)) dut0 (
    .clk_ser (clk_ser),
    .reset_n (reset_n),
    .clk_par (clk_par),
    .par_in  (par_in),
    .ser_out (ser_out0),
    .ser_in  (w_ser_in),
    .par_out (par_out0),
    .strobe  (strobe0)
  );

  serializer_deserializer #(.WIDTH(W), .LAUNCH_NEGEDGE(1'b1)) dut1 (
    .clk_ser (clk_ser),
    .reset_n (reset_n),
    .clk_par (clk_par),
    .par_in  (par_in),
    .ser_out (ser_out1),
    .ser_in  (w_ser_in),
    .par_out (par_out1),
    .strobe  (strobe1)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev   = 1'b1;
    m_word   = '0;
    m_idx    = W;
    m_hist.delete();
    m_par    = '0;
    m_strobe = 1'b0;
    m_ser    = 1'b0;
  endtask

  // One rising edge of the link, described at frame level.
  task automatic model_edge();
    logic         bit_in;
    logic         rose;
    logic [W-1:0] w;
    int           n;
    bit_in = loop_en ? m_ser : ser_in_drv;
    rose   = clk_par && !m_prev;
    m_prev = clk_par;
    m_hist.push_back(bit_in);
    if (m_hist.size() > W) void'(m_hist.pop_front());
    if (rose) begin
      // Latched word = last W received bits, newest in bit 0, pre-history zero.
      w = '0;
      n = m_hist.size();
      for (int j = 0; j < n; j++) w[j] = m_hist[n-1-j];
      m_par  = w;
      m_word = par_in;
      m_idx  = 0;
    end else if (m_idx < W) begin
      m_idx++;
    end
    m_ser    = (m_idx < W) ? m_word[W-1-m_idx] : 1'b0;
    m_strobe = rose;
  endtask

  // Advance one clk_ser period; inputs must already be set. Returns at negedge+2.
  task automatic cycle();
    logic old_ser;
    old_ser = m_ser;
    @(posedge clk_ser);
    model_edge();
    #2;
    check("ser_out_pos", {7'd0, ser_out0}, {7'd0, m_ser});
    check("strobe",      {7'd0, strobe0},  {7'd0, m_strobe});
    check("par_out",     par_out0, m_par);
    check("strobe_neg",  {7'd0, strobe1},  {7'd0, m_strobe});
    check("par_out_neg", par_out1, m_par);
    check("ser_out_neg_hold", {7'd0, ser_out1}, {7'd0, old_ser});
    @(negedge clk_ser);
    #2;
    check("ser_out_neg", {7'd0, ser_out1}, {7'd0, m_ser});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] a5, rx_word, mid_word;
    logic [W-1:0] words[4];
    int           strobes_seen;

    // Reset with clk_par high: no strobe on release.
    model_reset();
    reset_n = 1'b0;
    clk_par = 1'b1;
    #12;
    check("rst_ser_out0", {7'd0, ser_out0}, '0);
    check("rst_ser_out1", {7'd0, ser_out1}, '0);
    check("rst_par_out",  par_out0, '0);
    check("rst_strobe",   {7'd0, strobe0}, '0);
    reset_n = 1'b1;
    cycle();
    cycle();
    check("release_no_strobe", {7'd0, strobe0}, '0);

    // TX: load A5, expect 1,0,1,0,0,1,0,1 then zeros.
    a5 = 8'hA5;
    clk_par = 1'b0;
    cycle();
    par_in  = a5;
    clk_par = 1'b1;
    cycle();
    check("tx_a5_msb", {7'd0, ser_out0}, {7'd0, a5[7]});
    clk_par = 1'b0;
    for (int i = 1; i < 12; i++) begin
      par_in = W'($urandom);
      cycle();
      if (i < W) check("tx_a5_bit", {7'd0, ser_out0}, {7'd0, a5[W-1-i]});
      else       check("tx_zero_fill", {7'd0, ser_out0}, '0);
    end

    // RX: 3C MSB-first, strobe rises on the eighth bit edge.
    rx_word = 8'h3C;
    for (int i = 0; i < W; i++) begin
      ser_in_drv = rx_word[W-1-i];
      clk_par    = (i == W - 1);
      cycle();
    end
    check("rx_3c", par_out0, rx_word);
    // clk_par held high: exactly one strobe, word holds.
    strobes_seen = 0;
    for (int i = 0; i < 10; i++) begin
      ser_in_drv = 1'($urandom);
      cycle();
      if (strobe0) strobes_seen++;
    end
    check("held_high_strobes", W'(strobes_seen), '0);
    check("rx_hold", par_out0, rx_word);

    // Loopback: each strobe latches the word loaded at the previous strobe.
    words[0] = 8'h12; words[1] = 8'hF0; words[2] = 8'h81; words[3] = 8'h00;
    loop_en = 1'b1;
    clk_par = 1'b0;
    cycle();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < W; c++) begin
        clk_par = (c == 0);
        par_in  = words[k];
        cycle();
        if (c == 0 && k > 0) check("loop_word", par_out0, words[k-1]);
      end
    end

    // Randomized traffic: open-line and loopback phases.
    loop_en = 1'b0;
    for (int i = 0; i < 150; i++) begin
      ser_in_drv = 1'($urandom);
      clk_par    = ($urandom_range(0, 3) == 0);
      par_in     = W'($urandom);
      cycle();
    end
    loop_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      clk_par = ($urandom_range(0, 5) == 0);
      par_in  = W'($urandom);
      cycle();
    end

    // Mid-frame reset after three bits of FF.
    loop_en = 1'b0;
    clk_par = 1'b0;
    cycle();
    par_in  = 8'hFF;
    clk_par = 1'b1;
    cycle();
    clk_par = 1'b0;
    cycle();
    cycle();
    check("mid_frame_bit", {7'd0, ser_out0}, 8'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_ser_out0", {7'd0, ser_out0}, '0);
    check("midrst_ser_out1", {7'd0, ser_out1}, '0);
    check("midrst_par_out",  par_out0, '0);
    model_reset();
    #5;
    reset_n = 1'b1;
    cycle();
    check("post_rst_par_out", par_out0, '0);
    // Next frame after reset is carried correctly over loopback.
    mid_word = 8'h5A;
    loop_en  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < W; c++) begin
        clk_par = (c == 0);
        par_in  = (k == 0) ? mid_word : 8'h00;
        cycle();
      end
    end
    check("post_rst_frame", par_out0, mid_word);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
